// File: rtl/fpu_ss_wb_arbiter.sv
// Writeback arbiter for the FPU subsystem: shares the FP register-file write port
// between load and FPnew results, and registers integer-destination FPnew results toward X-IF.
module fpu_ss_wb_arbiter #(
  parameter int unsigned FLEN      = 32,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fpu_valid_i,
  output logic            fpu_ready_o,
  input  logic            fpu_rd_is_fp_i,
  input  logic [4:0]      fpu_rd_i,
  input  logic [3:0]      fpu_id_i,
  input  logic [FLEN-1:0] fpu_data_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      mem_rd_i,
  input  logic [FLEN-1:0] mem_data_i,
  output logic            fpr_we_o,
  output logic [4:0]      fpr_waddr_o,
  output logic [FLEN-1:0] fpr_wdata_o,
  output logic            x_result_valid_o,
  input  logic            x_result_ready_i,
  output logic [3:0]      x_result_id_o,
  output logic [4:0]      x_result_rd_o,
  output logic [FLEN-1:0] x_result_data_o,
  output logic            starve_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

  logic [CNT_W-1:0] stall_cnt_q;
  logic             fp_req;
  logic             int_req;
  logic             starve;
  logic             fp_gnt;
  logic             mem_gnt;
  logic             int_gnt;

  // Grant logic: loads win the FPR port unless FPnew has been denied MAX_STALL times in a row
  always_comb begin
    fp_req  = fpu_valid_i & fpu_rd_is_fp_i;
    int_req = fpu_valid_i & ~fpu_rd_is_fp_i;
    starve  = fp_req & (stall_cnt_q == STALL_MAX);
    fp_gnt  = fp_req & (~mem_valid_i | starve);
    mem_gnt = mem_valid_i & ~starve;
    int_gnt = int_req & (~x_result_valid_o | x_result_ready_i);
  end

  assign starve_o    = starve;
  assign mem_ready_o = ~starve;
  assign fpu_ready_o = fpu_rd_is_fp_i ? fp_gnt : int_gnt;
  assign busy_o      = fpr_we_o | x_result_valid_o;

  // Anti-starvation counter: consecutive cycles FPnew wanted the FPR port and lost
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (~fp_req || fp_gnt) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // FPR write register; address/data hold when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpr_we_o    <= 1'b0;
      fpr_waddr_o <= '0;
      fpr_wdata_o <= '0;
    end else begin
      fpr_we_o <= mem_gnt | fp_gnt;
      if (mem_gnt) begin
        fpr_waddr_o <= mem_rd_i;
        fpr_wdata_o <= mem_data_i;
      end else if (fp_gnt) begin
        fpr_waddr_o <= fpu_rd_i;
        fpr_wdata_o <= fpu_data_i;
      end
    end
  end

  // One-entry X-IF result register, reloads on the same edge it drains
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_result_valid_o <= 1'b0;
      x_result_id_o    <= '0;
      x_result_rd_o    <= '0;
      x_result_data_o  <= '0;
    end else if (int_gnt) begin
      x_result_valid_o <= 1'b1;
      x_result_id_o    <= fpu_id_i;
      x_result_rd_o    <= fpu_rd_i;
      x_result_data_o  <= fpu_data_i;
    end else if (x_result_valid_o && x_result_ready_i) begin
      x_result_valid_o <= 1'b0;
    end
  end

endmodule
